// File: rtl/lvds_tx_frame_gen.sv
// rtl/lvds_tx_frame_gen.sv - LVDS transmit framer: training burst, sync marker burst, then payload/idle words
module lvds_tx_frame_gen #(
    parameter logic [9:0] TRAIN_WORD     = 10'b1111100000,
    parameter int         TRAIN_LEN      = 256,
    parameter logic [9:0] SYNC_WORD      = 10'b1100110011,
    parameter int         SYNC_LEN       = 16,
    parameter logic [9:0] IDLE_WORD      = 10'b1010101010,
    parameter int         REALIGN_PERIOD = 0,
    parameter int         CNT_W          = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_locked,
    input  logic       align_req,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic [9:0] tx_data,
    output logic       link_up,
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_TRAIN = 2'd1,
        S_SYNC  = 2'd2,
        S_DATA  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] TRAIN_LAST = CNT_W'(TRAIN_LEN - 1);
    localparam logic [CNT_W-1:0] SYNC_LAST  = CNT_W'(SYNC_LEN - 1);
    localparam logic [CNT_W-1:0] PER_LAST   =
        (REALIGN_PERIOD == 0) ? '0 : CNT_W'(REALIGN_PERIOD - 1);

    state_t           state_q, state_d;
    logic [9:0]       tx_data_q, tx_data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] per_q, per_d;

    always_comb begin
        state_d   = state_q;
        tx_data_d = IDLE_WORD;
        cnt_d     = cnt_q;
        per_d     = per_q;
        case (state_q)
            S_IDLE: begin
                tx_data_d = IDLE_WORD;
                cnt_d     = '0;
                per_d     = '0;
                if (tx_locked) begin
                    state_d = S_TRAIN;
                end
            end
            S_TRAIN: begin
                tx_data_d = TRAIN_WORD;
                if (cnt_q == TRAIN_LAST) begin
                    state_d = S_SYNC;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SYNC: begin
                tx_data_d = SYNC_WORD;
                if (cnt_q == SYNC_LAST) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                    per_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                tx_data_d = data_valid ? {2'b01, data_in} : IDLE_WORD;
                if (REALIGN_PERIOD != 0) begin
                    if (per_q == PER_LAST) begin
                        state_d = S_TRAIN;
                        cnt_d   = '0;
                        per_d   = '0;
                    end else begin
                        per_d = per_q + 1'b1;
                    end
                end
                if (align_req) begin
                    state_d = S_TRAIN;
                    cnt_d   = '0;
                    per_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Lock loss wins, but a byte already handshaken in DATA is still sent.
        if (!tx_locked) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            per_d   = '0;
            if (state_q != S_DATA) begin
                tx_data_d = IDLE_WORD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            tx_data_q <= 10'h000;
            cnt_q     <= '0;
            per_q     <= '0;
        end else begin
            state_q   <= state_d;
            tx_data_q <= tx_data_d;
            cnt_q     <= cnt_d;
            per_q     <= per_d;
        end
    end

    assign tx_data    = tx_data_q;
    assign data_ready = (state_q == S_DATA);
    assign link_up    = (state_q == S_DATA);
    assign state_o    = state_q;

endmodule

// File: tb/tb_lvds_tx_frame_gen.sv
// tb/tb_lvds_tx_frame_gen.sv - randomized directed bench for lvds_tx_frame_gen against a word-script model
module tb_lvds_tx_frame_gen;

    localparam logic [9:0] TRAIN_W = 10'h3E0;
    localparam logic [9:0] SYNC_W  = 10'h333;
    localparam logic [9:0] IDLE_W  = 10'h2AA;
    localparam int         T_LEN   = 256;
    localparam int         S_LEN   = 16;
    localparam int         PERIOD  = 100;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tx_locked;
    logic       align_req;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready;
    logic [9:0] tx_data;
    logic       link_up;
    logic [1:0] state_o;

    int n_assert = 0;
    int n_fail   = 0;

    lvds_tx_frame_gen #(
        .REALIGN_PERIOD(PERIOD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_locked  (tx_locked),
        .align_req  (align_req),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .tx_data    (tx_data),
        .link_up    (link_up),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    // Model: phase 0 idle, 1 burst (replaying a script of expected words), 2 data
    int         m_phase = 0;
    logic [9:0] m_script[$];
    int         m_data_cnt = 0;
    logic [9:0] m_tx = 10'h000;

    task automatic load_burst();
        m_script.delete();
        for (int i = 0; i < T_LEN; i++) m_script.push_back(TRAIN_W);
        for (int i = 0; i < S_LEN; i++) m_script.push_back(SYNC_W);
        m_phase = 1;
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            m_phase = 0;
            m_script.delete();
            m_tx = 10'h000;
        end else if (m_phase == 0) begin
            m_tx = IDLE_W;
            if (tx_locked) load_burst();
        end else if (m_phase == 1) begin
            if (!tx_locked) begin
                m_tx = IDLE_W;
                m_phase = 0;
                m_script.delete();
            end else begin
                m_tx = m_script.pop_front();
                if (m_script.size() == 0) begin
                    m_phase = 2;
                    m_data_cnt = 0;
                end
            end
        end else begin
            m_tx = data_valid ? {2'b01, data_in} : IDLE_W;
            if (!tx_locked) begin
                m_phase = 0;
            end else begin
                m_data_cnt++;
                if (align_req || m_data_cnt == PERIOD) load_burst();
            end
        end
    endtask

    function automatic logic [1:0] m_state();
        if (m_phase == 0) return 2'd0;
        if (m_phase == 2) return 2'd3;
        return (m_script.size() > S_LEN) ? 2'd1 : 2'd2;
    endfunction

    task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic lk, input logic ar, input logic dv, input logic [7:0] d);
        tx_locked  = lk;
        align_req  = ar;
        data_valid = dv;
        data_in    = d;
        @(posedge clk);
        model_edge();
        #1;
        check("tx_data", tx_data, m_tx);
        check("state_o", {8'd0, state_o}, {8'd0, m_state()});
        check("link_up", {9'd0, link_up}, {9'd0, m_phase == 2});
        check("data_ready", {9'd0, data_ready}, {9'd0, m_phase == 2});
    endtask

    task automatic rand_step(input logic lk, input logic ar);
        step(lk, ar, 1'($urandom_range(0, 1)), 8'($urandom));
    endtask

    task automatic run_to_data(input int limit);
        int k;
        k = 0;
        while (!link_up && k < limit) begin
            rand_step(1'b1, 1'($urandom_range(0, 7) == 0));
            k++;
        end
        check("reach_data", {9'd0, link_up}, 10'd1);
    endtask

    initial begin
        int run;
        rst_n = 1'b0;
        tx_locked = 1'b0; align_req = 1'b0; data_valid = 1'b0; data_in = 8'h00;
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b1, 1'b1, 8'hFF);
        check("reset_tx", tx_data, 10'h000);
        check("reset_state", {8'd0, state_o}, 10'd0);
        rst_n = 1'b1;

        // Power-up: one idle word, then full training and sync bursts
        step(1'b1, 1'b0, 1'b0, 8'h00);
        check("first_idle", tx_data, IDLE_W);
        run = 0;
        while (!link_up && run < 400) begin
            step(1'b1, 1'b0, 1'b0, 8'h00);
            run++;
        end
        check("burst_len", 10'(run), 10'(T_LEN + S_LEN));

        step(1'b1, 1'b0, 1'b1, 8'hA5);
        check("payload_a5", tx_data, 10'h1A5);
        step(1'b1, 1'b0, 1'b0, 8'h5A);
        check("idle_fill", tx_data, IDLE_W);

        // align_req together with a valid byte: byte sent, then retrain
        step(1'b1, 1'b1, 1'b1, 8'h3C);
        check("align_byte", tx_data, 10'h13C);
        check("align_state", {8'd0, state_o}, 10'd1);
        for (int i = 0; i < 60; i++) rand_step(1'b1, 1'($urandom_range(0, 3) == 0));
        run_to_data(400);

        // Periodic retrain: stay in DATA with no requests until it fires
        run = 0;
        while (link_up && run < 200) begin
            rand_step(1'b1, 1'b0);
            run++;
        end
        check("period_len", 10'(run), 10'(PERIOD));

        // Lock loss at training word 50
        for (int i = 0; i < 49; i++) rand_step(1'b1, 1'($urandom_range(0, 1)));
        step(1'b0, 1'b0, 1'b0, 8'h00);
        check("unlock_idle", tx_data, IDLE_W);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        run = 0;
        while (!link_up && run < 400) begin
            rand_step(1'b1, 1'b0);
            run++;
        end
        check("relock_burst", 10'(run), 10'(T_LEN + S_LEN));

        // Lock loss in DATA with a valid byte: byte still transmitted
        step(1'b0, 1'b0, 1'b1, 8'h77);
        check("unlock_byte", tx_data, 10'h177);
        check("unlock_state", {8'd0, state_o}, 10'd0);
        run_to_data(400);

        // Reset for one cycle in DATA
        for (int i = 0; i < 10; i++) rand_step(1'b1, 1'b0);
        rst_n = 1'b0;
        step(1'b1, 1'b0, 1'b1, 8'h11);
        check("rst_mid_tx", tx_data, 10'h000);
        rst_n = 1'b1;
        run_to_data(400);

        // Random soak with occasional requests and lock drops
        for (int i = 0; i < 3000; i++)
            rand_step(1'($urandom_range(0, 299) != 0), 1'($urandom_range(0, 49) == 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
